// File: rtl/sonar_pkg.sv
// Shared encodings and frame characters for the sonar serial link,
// used by both the transmit mux and this receiver.
package sonar_pkg;

  typedef enum logic [3:0] {
    RX_INICIAL  = 4'd0,
    RX_INICIO   = 4'd1,
    RX_DADOS    = 4'd2,
    RX_PARIDADE = 4'd3,
    RX_PARADA   = 4'd4
  } rx_state_t;

  typedef enum logic [3:0] {
    FR_A2     = 4'd0,
    FR_A1     = 4'd1,
    FR_A0     = 4'd2,
    FR_VIRG   = 4'd3,
    FR_D2     = 4'd4,
    FR_D1     = 4'd5,
    FR_D0     = 4'd6,
    FR_FIM    = 4'd7,
    FR_RESYNC = 4'd8
  } frame_state_t;

  localparam logic [6:0] ASCII_VIRG = 7'h2C;
  localparam logic [6:0] ASCII_FIM  = 7'h23;
  localparam logic [6:0] ASCII_ZERO = 7'h30;

endpackage

// File: rtl/rx_serial_7O1.sv
// 7O1 UART character receiver: synchronizer, mid-bit sampling, odd parity
// and stop-bit check, with one-cycle result strobes.
module rx_serial_7O1
  import sonar_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [6:0] dado,
  output logic       char_valido,
  output logic       erro_paridade,
  output logic       erro_parada,
  output logic [3:0] db_estado
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  function automatic logic parity_ok(input logic [6:0] d, input logic p);
    return ^{d, p};
  endfunction

  rx_state_t      state;
  logic           sync_p0, sync_p1, line_p2;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_idx;
  logic [6:0]     shift;
  logic           par_bit;
  logic           half_hit, full_hit;

  assign half_hit  = (cnt == CW'(HALF - 1));
  assign full_hit  = (cnt == CW'(CLKS_PER_BIT - 1));
  assign dado      = shift;
  assign db_estado = state;

  // Synchronizer resets low so a line held low through reset release never
  // looks like a start edge; the line must be seen high first.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0       <= 1'b0;
      sync_p1       <= 1'b0;
      line_p2       <= 1'b0;
      state         <= RX_INICIAL;
      cnt           <= '0;
      bit_idx       <= '0;
      char_valido   <= 1'b0;
      erro_paridade <= 1'b0;
      erro_parada   <= 1'b0;
    end else begin
      sync_p0       <= entrada_serial;
      sync_p1       <= sync_p0;
      line_p2       <= sync_p1;
      char_valido   <= 1'b0;
      erro_paridade <= 1'b0;
      erro_parada   <= 1'b0;
      case (state)
        RX_INICIAL: begin
          cnt <= '0;
          if (line_p2 && !sync_p1) state <= RX_INICIO;
        end
        RX_INICIO: begin
          if (half_hit) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= sync_p1 ? RX_INICIAL : RX_DADOS;
          end else cnt <= cnt + CW'(1);
        end
        RX_DADOS: begin
          if (full_hit) begin
            cnt <= '0;
            if (bit_idx == 3'd6) state <= RX_PARIDADE;
            else bit_idx <= bit_idx + 3'd1;
          end else cnt <= cnt + CW'(1);
        end
        RX_PARIDADE: begin
          if (full_hit) begin
            cnt   <= '0;
            state <= RX_PARADA;
          end else cnt <= cnt + CW'(1);
        end
        RX_PARADA: begin
          if (full_hit) begin
            cnt   <= '0;
            state <= RX_INICIAL;
            if (!sync_p1) erro_parada <= 1'b1;
            else if (!parity_ok(shift, par_bit)) erro_paridade <= 1'b1;
            else char_valido <= 1'b1;
          end else cnt <= cnt + CW'(1);
        end
        default: state <= RX_INICIAL;
      endcase
    end
  end

  // Character payload: data only, no reset needed
  always_ff @(posedge clock) begin
    if (state == RX_DADOS && full_hit) shift <= {sync_p1, shift[6:1]};
    if (state == RX_PARIDADE && full_hit) par_bit <= sync_p1;
  end

endmodule

// File: rtl/sonar_frame_rx.sv
// Sonar frame receiver: parses "ccc,ddd#" characters from the 7O1 line into
// BCD angle/distance with a ready strobe and line/format error strobes.
module sonar_frame_rx
  import sonar_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_serial,
  output logic [11:0] angulo,
  output logic [11:0] distancia,
  output logic        pronto,
  output logic        erro_paridade,
  output logic        erro_quadro,
  output logic [3:0]  db_estado_rx,
  output logic [3:0]  db_estado_frame
);

  function automatic logic is_digit(input logic [6:0] c);
    return (c >= ASCII_ZERO) && (c <= ASCII_ZERO + 7'd9);
  endfunction

  logic [6:0]   dado;
  logic         rx_char, rx_par, rx_stop;
  logic         fmt_err;
  frame_state_t fr_state;
  logic [23:0]  stage;

  rx_serial_7O1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock         (clock),
    .reset         (reset),
    .entrada_serial(entrada_serial),
    .dado          (dado),
    .char_valido   (rx_char),
    .erro_paridade (rx_par),
    .erro_parada   (rx_stop),
    .db_estado     (db_estado_rx)
  );

  // Stop errors and format errors can never land in the same cycle:
  // a format error trails its character by one cycle, the next stop sample
  // is a whole character later.
  assign erro_quadro     = fmt_err | rx_stop;
  assign erro_paridade   = rx_par;
  assign db_estado_frame = fr_state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fr_state  <= FR_A2;
      angulo    <= '0;
      distancia <= '0;
      pronto    <= 1'b0;
      fmt_err   <= 1'b0;
    end else begin
      pronto  <= 1'b0;
      fmt_err <= 1'b0;
      if (rx_char) begin
        case (fr_state)
          FR_A2, FR_A1, FR_A0, FR_D2, FR_D1, FR_D0: begin
            if (is_digit(dado)) begin
              case (fr_state)
                FR_A2:   fr_state <= FR_A1;
                FR_A1:   fr_state <= FR_A0;
                FR_A0:   fr_state <= FR_VIRG;
                FR_D2:   fr_state <= FR_D1;
                FR_D1:   fr_state <= FR_D0;
                default: fr_state <= FR_FIM;
              endcase
            end else begin
              fmt_err  <= 1'b1;
              fr_state <= (dado == ASCII_FIM) ? FR_A2 : FR_RESYNC;
            end
          end
          FR_VIRG: begin
            if (dado == ASCII_VIRG) fr_state <= FR_D2;
            else begin
              fmt_err  <= 1'b1;
              fr_state <= (dado == ASCII_FIM) ? FR_A2 : FR_RESYNC;
            end
          end
          FR_FIM: begin
            if (dado == ASCII_FIM) begin
              angulo    <= stage[23:12];
              distancia <= stage[11:0];
              pronto    <= 1'b1;
              fr_state  <= FR_A2;
            end else begin
              fmt_err  <= 1'b1;
              fr_state <= FR_RESYNC;
            end
          end
          FR_RESYNC: if (dado == ASCII_FIM) fr_state <= FR_A2;
          default:   fr_state <= FR_A2;
        endcase
      end else if ((rx_par || rx_stop) && fr_state != FR_A2 && fr_state != FR_RESYNC) begin
        fr_state <= FR_RESYNC;
      end
    end
  end

  // Staging digits: only ever read after a complete frame has refilled them
  always_ff @(posedge clock) begin
    if (rx_char && is_digit(dado)) begin
      case (fr_state)
        FR_A2:   stage[23:20] <= dado[3:0];
        FR_A1:   stage[19:16] <= dado[3:0];
        FR_A0:   stage[15:12] <= dado[3:0];
        FR_D2:   stage[11:8]  <= dado[3:0];
        FR_D1:   stage[7:4]   <= dado[3:0];
        FR_D0:   stage[3:0]   <= dado[3:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_frame_rx.sv
// Directed bench for sonar_frame_rx at 8 clocks per bit.
module tb_sonar_frame_rx;

  localparam int CPB = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        entrada_serial;
  logic [11:0] angulo, distancia;
  logic        pronto, erro_paridade, erro_quadro;
  logic [3:0]  db_estado_rx, db_estado_frame;

  int vectors = 0;
  int miscompares = 0;
  int n_pronto = 0, n_par = 0, n_quad = 0;
  logic [11:0] ang_log[$];
  logic [11:0] dist_log[$];

  sonar_frame_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .angulo         (angulo),
    .distancia      (distancia),
    .pronto         (pronto),
    .erro_paridade  (erro_paridade),
    .erro_quadro    (erro_quadro),
    .db_estado_rx   (db_estado_rx),
    .db_estado_frame(db_estado_frame)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (pronto) begin
      n_pronto++;
      ang_log.push_back(angulo);
      dist_log.push_back(distancia);
    end
    if (erro_paridade) n_par++;
    if (erro_quadro) n_quad++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic send_bit(input logic b);
    entrada_serial = b;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_char(input logic [6:0] c, input bit flip, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 7; i++) send_bit(c[i]);
    send_bit((~^c) ^ flip);
    send_bit(stop);
    entrada_serial = 1'b1;
  endtask

  task automatic send_str(input string s, input int flip_idx);
    byte b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      send_char(b[6:0], i == flip_idx, 1'b1);
    end
  endtask

  task automatic idle(input int n);
    entrada_serial = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  int p0, e0, q0, base;
  logic [11:0] a_first, d_first, a_second, d_second;

  initial begin
    entrada_serial = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("reset angulo", angulo, 12'h000);
    check("reset distancia", distancia, 12'h000);
    check("reset pronto", pronto, 1'b0);
    check("reset erro_paridade", erro_paridade, 1'b0);
    check("reset erro_quadro", erro_quadro, 1'b0);
    check("reset rx state", db_estado_rx, 4'd0);
    check("reset frame state", db_estado_frame, 4'd0);
    reset = 1'b1;
    idle(10);

    // Good frame
    p0 = n_pronto; e0 = n_par; q0 = n_quad;
    send_str("090,123#", -1);
    idle(20);
    check("good pronto count", n_pronto - p0, 1);
    check("good angulo", angulo, 12'h090);
    check("good distancia", distancia, 12'h123);
    check("good no parity err", n_par - e0, 0);
    check("good no frame err", n_quad - q0, 0);

    // Parity error on the '1', then the same frame cleanly
    p0 = n_pronto; e0 = n_par; q0 = n_quad;
    send_str("045,010#", 5);
    idle(20);
    check("parity err count", n_par - e0, 1);
    check("parity no pronto", n_pronto - p0, 0);
    check("parity no frame err", n_quad - q0, 0);
    check("parity angulo held", angulo, 12'h090);
    check("parity distancia held", distancia, 12'h123);
    check("parity frame state", db_estado_frame, 4'd0);
    p0 = n_pronto;
    send_str("045,010#", -1);
    idle(20);
    check("reclean pronto", n_pronto - p0, 1);
    check("reclean angulo", angulo, 12'h045);
    check("reclean distancia", distancia, 12'h010);

    // Format error then resync
    p0 = n_pronto; e0 = n_par; q0 = n_quad;
    send_str("09,123#180,200#", -1);
    idle(20);
    check("format err count", n_quad - q0, 1);
    check("format pronto count", n_pronto - p0, 1);
    check("format angulo", angulo, 12'h180);
    check("format distancia", distancia, 12'h200);
    check("format no parity err", n_par - e0, 0);

    // Stop-bit error, then an idle-line glitch
    p0 = n_pronto; e0 = n_par; q0 = n_quad;
    send_char(7'h35, 1'b0, 1'b0);
    idle(20);
    check("stop err count", n_quad - q0, 1);
    check("stop no parity err", n_par - e0, 0);
    check("stop no pronto", n_pronto - p0, 0);
    check("stop frame state", db_estado_frame, 4'd0);
    q0 = n_quad;
    entrada_serial = 1'b0;
    repeat (3) @(negedge clock);
    idle(30);
    check("glitch no frame err", n_quad - q0, 0);
    check("glitch no parity err", n_par - e0, 0);
    check("glitch no pronto", n_pronto - p0, 0);
    check("glitch rx state", db_estado_rx, 4'd0);

    // Reset mid-frame
    p0 = n_pronto; e0 = n_par; q0 = n_quad;
    send_str("12", -1);
    reset = 1'b0;
    @(negedge clock);
    check("midreset angulo", angulo, 12'h000);
    check("midreset distancia", distancia, 12'h000);
    check("midreset frame state", db_estado_frame, 4'd0);
    idle(4);
    reset = 1'b1;
    idle(10);
    check("midreset no pulses", (n_pronto - p0) + (n_par - e0) + (n_quad - q0), 0);
    check("after reset angulo", angulo, 12'h000);
    send_str("120,300#", -1);
    idle(20);
    check("post reset pronto", n_pronto - p0, 1);
    check("post reset angulo", angulo, 12'h120);
    check("post reset distancia", distancia, 12'h300);

    // Back-to-back frames, no idle between characters
    p0 = n_pronto; e0 = n_par; q0 = n_quad;
    base = ang_log.size();
    send_str("123,456#789,012#", -1);
    idle(20);
    check("b2b pronto count", n_pronto - p0, 2);
    check("b2b errors", (n_par - e0) + (n_quad - q0), 0);
    a_first  = (ang_log.size()  > base)     ? ang_log[base]      : 12'hxxx;
    d_first  = (dist_log.size() > base)     ? dist_log[base]     : 12'hxxx;
    a_second = (ang_log.size()  > base + 1) ? ang_log[base + 1]  : 12'hxxx;
    d_second = (dist_log.size() > base + 1) ? dist_log[base + 1] : 12'hxxx;
    check("b2b first angulo", a_first, 12'h123);
    check("b2b first distancia", d_first, 12'h456);
    check("b2b second angulo", a_second, 12'h789);
    check("b2b second distancia", d_second, 12'h012);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
